// File: rtl/dispatch_pkg.sv
// Shared types and opcode constants for the dispatch scheduler and its decoder.
package dispatch_pkg;

  localparam int NUM_IQ = 4;

  typedef enum logic [1:0] {
    Q_INT  = 2'd0,
    Q_MULT = 2'd1,
    Q_DIV  = 2'd2,
    Q_LDST = 2'd3
  } queue_e;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  function automatic logic [NUM_IQ-1:0] queue_onehot(input queue_e q);
    return NUM_IQ'(1) << q;
  endfunction

endpackage

// File: rtl/instr_class_dec.sv
// Combinational classifier: maps an instruction onto its issue queue or flags it illegal.
module instr_class_dec
  import dispatch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]  instr,
  output logic [NUM_IQ-1:0] queue_oh,
  output logic              illegal
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       unused_ok;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[31:25];
  assign unused_ok = ^instr;

  always_comb begin
    queue_oh = '0;
    illegal  = 1'b0;
    case (opcode)
      OP_REG: begin
        if (funct7 == FUNCT7_MULDIV)
          queue_oh = funct3[2] ? queue_onehot(Q_DIV) : queue_onehot(Q_MULT);
        else
          queue_oh = queue_onehot(Q_INT);
      end
      OP_IMM, OP_LUI, OP_AUIPC, OP_BRANCH, OP_JAL, OP_JALR:
        queue_oh = queue_onehot(Q_INT);
      OP_LOAD, OP_STORE:
        queue_oh = queue_onehot(Q_LDST);
      default:
        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/dispatch_sched.sv
// Drains the fetch queue through a one-entry stage into four issue queues, tagging each
// dispatch from a ROB tag counter; a mispredict flush empties the fetch queue and reloads the tag.
module dispatch_sched
  import dispatch_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TAG_W   = 5,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ifq_empty,
  input  logic [WIDTH-1:0]   ifq_data,
  output logic               ifq_pull,
  input  logic [NUM_IQ-1:0]  iq_full,
  output logic [NUM_IQ-1:0]  iq_push,
  output logic [WIDTH-1:0]   iq_instr,
  output logic [TAG_W-1:0]   iq_tag,
  input  logic               rob_full,
  input  logic               flush,
  input  logic [TAG_W-1:0]   flush_tag,
  output logic               flush_busy,
  output logic               illegal,
  output logic [STALL_W-1:0] stall_cnt
);

  state_e              state_reg;
  logic                valid_reg;
  logic [WIDTH-1:0]    instr_reg;
  logic [NUM_IQ-1:0]   qsel_reg;
  logic [TAG_W-1:0]    tag_reg;
  logic [STALL_W-1:0]  stall_reg;
  logic                illegal_reg;

  logic [NUM_IQ-1:0]   dec_oh;
  logic                dec_illegal;
  logic [NUM_IQ-1:0]   target_full;
  logic                stage_fire;

  instr_class_dec #(.WIDTH(WIDTH)) u_dec (
    .instr    (ifq_data),
    .queue_oh (dec_oh),
    .illegal  (dec_illegal)
  );

  // Only the full flag of the queue this entry targets matters.
  generate
    for (genvar gi = 0; gi < NUM_IQ; gi++) begin : g_iq
      assign target_full[gi] = qsel_reg[gi] & iq_full[gi];
      assign iq_push[gi]     = qsel_reg[gi] & stage_fire;
    end
  endgenerate

  assign stage_fire = valid_reg & ~(|target_full) & ~rob_full & ~flush & (state_reg == RUN);

  always_comb begin
    ifq_pull = 1'b0;
    if (rst && !flush) begin
      case (state_reg)
        RUN:     ifq_pull = !ifq_empty && (!valid_reg || stage_fire);
        FLUSH:   ifq_pull = !ifq_empty;
        default: ifq_pull = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= RUN;
      valid_reg   <= 1'b0;
      instr_reg   <= '0;
      qsel_reg    <= '0;
      tag_reg     <= '0;
      stall_reg   <= '0;
      illegal_reg <= 1'b0;
    end else begin
      illegal_reg <= 1'b0;
      if (flush) begin
        valid_reg <= 1'b0;
        tag_reg   <= flush_tag;
        state_reg <= FLUSH;
      end else begin
        case (state_reg)
          RUN: begin
            if (stage_fire)
              tag_reg <= tag_reg + 1'b1;
            else if (valid_reg && stall_reg != '1)
              stall_reg <= stall_reg + 1'b1;
            // Illegal heads are consumed but never occupy the stage.
            if (ifq_pull) begin
              valid_reg   <= !dec_illegal;
              instr_reg   <= ifq_data;
              qsel_reg    <= dec_oh;
              illegal_reg <= dec_illegal;
            end else if (stage_fire) begin
              valid_reg <= 1'b0;
            end
          end
          FLUSH: begin
            if (ifq_empty)
              state_reg <= RUN;
          end
          default: state_reg <= RUN;
        endcase
      end
    end
  end

  assign iq_instr   = instr_reg;
  assign iq_tag     = tag_reg;
  assign flush_busy = (state_reg == FLUSH);
  assign illegal    = illegal_reg;
  assign stall_cnt  = stall_reg;

endmodule

// File: doc/dispatch_sched.md
Name: dispatch_sched

Overview:
Scheduler that drains the instruction fetch queue (fifo_param instance) in the dispatch unit. It decodes each instruction into one of four issue queues: integer, multiply, divide or load/store. It allocates a ROB tag and pushes the instruction only when the target queue and the ROB both have room. On a branch mispredict it flushes the fetch queue by pulling it dry and reloads the tag counter.

Parameters:
WIDTH, 32, instruction width; must match the fetch-queue WIDTH.
TAG_W, 5, ROB tag width.
STALL_W, 16, width of the saturating stall counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
ifq_empty  in  1  fetch queue empty.
ifq_data  in  WIDTH  fetch queue head (combinational data_out of the queue).
ifq_pull  out  1  pop the fetch queue head this cycle.
iq_full  in  4  per-queue full: [0] int, [1] mult, [2] div, [3] ldst.
iq_push  out  4  one-hot push to the target issue queue.
iq_instr  out  WIDTH  instruction to the issue queues.
iq_tag  out  TAG_W  ROB tag accompanying the push.
rob_full  in  1  no tag available; blocks dispatch.
flush  in  1  mispredict pulse, one cycle.
flush_tag  in  TAG_W  next tag to allocate after a flush.
flush_busy  out  1  flush in progress; fetch must not push.
illegal  out  1  one-cycle pulse when an undecodable instruction is discarded.
stall_cnt  out  STALL_W  saturating count of cycles the stage was held.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN; stage valid=0; tag counter=0; stall_cnt=0.
  - All outputs 0, including flush_busy.
- Decode (combinational on ifq_data[6:0]):
  - 0110011 with funct7=0000001: funct3[2]=0 -> mult; funct3[2]=1 -> div.
  - 0110011 otherwise, 0010011, 0110111, 0010111, 1100011, 1101111, 1100111 -> int.
  - 0000011, 0100011 -> ldst.
  - Anything else -> illegal.
- Stage register: one entry holding {valid, instr, queue one-hot}.
- stage_fire = valid & !iq_full[target] & !rob_full.
- RUN state:
  - ifq_pull = !ifq_empty & (!valid | stage_fire).
  - On pull, the decoded head loads the stage on the next edge; latency is one cycle from pull to the earliest push.
  - An illegal head is pulled but not loaded: illegal pulses on the cycle after the pull, and valid follows the normal rule.
  - iq_push = queue one-hot & {4{stage_fire}}; iq_instr and iq_tag are driven from the stage and the tag counter.
  - On stage_fire the tag counter increments, wrapping 2^TAG_W-1 -> 0.
  - valid & !stage_fire -> stall_cnt += 1, saturating at all-ones.
  - Back-to-back: with no stalls the block sustains one dispatch per cycle.
- flush (any state, highest priority):
  - Next edge: valid=0, tag counter=flush_tag, state=FLUSH.
  - No push or pull occurs in the flush cycle.
- FLUSH state:
  - flush_busy=1; ifq_pull = !ifq_empty; data is discarded; no decode, no illegal pulse.
  - ifq_empty=1 sampled -> RUN on the next edge; flush_busy drops with the state.
  - A flush arriving during FLUSH reloads the tag and remains in FLUSH.
- rob_full blocks stage_fire only; pulls continue until the stage is occupied.
- iq_push is never asserted to a full queue; ifq_pull is never asserted while ifq_empty=1.
- Reset asserted mid-operation discards the stage without any push.

Decomposition:
- Package dispatch_pkg:
  - queue_e enum (Q_INT, Q_MULT, Q_DIV, Q_LDST) and the one-hot width constant NUM_IQ=4.
  - Opcode localparams and the state_e enum (RUN, FLUSH).
- Sub-module instr_class_dec: combinational decode from instruction to {queue one-hot, illegal}, reusable by the issue logic.

Test Plan:
- Reset then push 0x00A00093 (addi) into the fetch queue -> ifq_pull cycle N; iq_push=0001, iq_tag=0 at N+1; a second addi gets tag 1 at N+2.
- mul 0x02208033 followed by div 0x0220C033 -> iq_push=0010 then 0100, tags consecutive, no bubble.
- iq_full[3]=1 for 5 cycles with a load 0x00002083 staged -> no push, ifq_pull=0 after the stage fills, stall_cnt=5; push 1000 on the cycle iq_full drops.
- 3 entries queued, flush with flush_tag=0x12 -> flush_busy=1 for 3 pull cycles plus one cycle to observe empty; the next dispatch carries tag 0x12.
- Head 0xFFFFFFFF -> pulled, illegal=1 for one cycle, no iq_push, tag unchanged.
- Tag counter at 31 with 2 dispatches -> tags 31 then 0; rob_full=1 holds the stage and iq_push=0.
